// File: rtl/hex_field_writer_pkg.sv
// Shared display definitions: field-writer states and text-code constants.
package hex_field_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_FLUSH = 2'd2
  } hfw_state_e;

  localparam logic [7:0] BLANK_CODE_DEFAULT = 8'd0;
  localparam logic [7:0] DIGIT_BASE         = 8'd16;
  localparam logic [7:0] LETTER_BASE        = 8'd33;

  // 0-9 map onto the digit glyph run, A-F onto the letter glyph run
  function automatic logic [7:0] nibble_code(input logic [3:0] nib);
    logic [7:0] code;
    if (nib < 4'd10) begin
      code = DIGIT_BASE + {4'd0, nib};
    end else begin
      code = LETTER_BASE + {4'd0, nib} - 8'd10;
    end
    return code;
  endfunction

endpackage

// File: rtl/nibble_to_hex_text.sv
// Registered nibble-to-text-code converter with a one-cycle valid pipeline.
module nibble_to_hex_text
  import hex_field_writer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [3:0] nibble,
  output logic       out_valid,
  output logic [7:0] code
);

  // Conversion register; valid is reset so nothing stale leaves after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      code      <= 8'd0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        code <= nibble_code(nibble);
      end else begin
        code <= code;
      end
    end
  end

endmodule

// File: rtl/hex_field_writer.sv
// Renders a 1..8 digit hex field into text RAM, one write per cycle, with
// optional leading-zero blanking.
module hex_field_writer
  import hex_field_writer_pkg::*;
#(
  parameter int         ADDR_W     = 11,
  parameter logic [7:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_value,
  input  logic [3:0]        req_ndigits,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_lz_blank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done
);

  hfw_state_e        state_r, state_nx_s;
  logic              accept_s, issue_s, last_s, blank_s;
  logic [31:0]       value_r;
  logic [2:0]        ndig_m1_r, idx_r, pos_s;
  logic [ADDR_W-1:0] addr_r, addr_d_r;
  logic              lz_r, seen_nz_r, blank_d_r, done_r;
  logic [3:0]        nib_s;
  logic              conv_valid_s;
  logic [7:0]        conv_code_s;

  assign pos_s   = ndig_m1_r - idx_r;
  assign nib_s   = value_r[{pos_s, 2'b00} +: 4];
  assign last_s  = (idx_r == ndig_m1_r);
  assign blank_s = lz_r && !seen_nz_r && (nib_s == 4'd0) && !last_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    issue_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s   = 1'b1;
          state_nx_s = ST_EMIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        issue_s = 1'b1;
        if (last_s) begin
          state_nx_s = ST_FLUSH;
        end else begin
          state_nx_s = ST_EMIT;
        end
      end
      ST_FLUSH: state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  assign req_ready = (state_r == ST_IDLE);

  // Request capture and digit walk; a count of 0 (or 8) wraps to N-1 = 7
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_r   <= 32'd0;
      ndig_m1_r <= 3'd0;
      addr_r    <= '0;
      lz_r      <= 1'b0;
      idx_r     <= 3'd0;
      seen_nz_r <= 1'b0;
    end else if (accept_s) begin
      value_r   <= req_value;
      ndig_m1_r <= req_ndigits[2:0] - 3'd1;
      addr_r    <= req_addr;
      lz_r      <= req_lz_blank;
      idx_r     <= 3'd0;
      seen_nz_r <= 1'b0;
    end else if (issue_s) begin
      idx_r     <= idx_r + 3'd1;
      seen_nz_r <= seen_nz_r | (nib_s != 4'd0);
    end else begin
      idx_r     <= idx_r;
      seen_nz_r <= seen_nz_r;
    end
  end

  // Side-band delayed one cycle to line up with the converter output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_d_r  <= '0;
      blank_d_r <= 1'b0;
      done_r    <= 1'b0;
    end else if (issue_s) begin
      addr_d_r  <= addr_r + {{(ADDR_W-3){1'b0}}, idx_r};
      blank_d_r <= blank_s;
      done_r    <= last_s;
    end else begin
      addr_d_r  <= addr_d_r;
      blank_d_r <= 1'b0;
      done_r    <= 1'b0;
    end
  end

  nibble_to_hex_text u_conv (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (issue_s),
    .nibble    (nib_s),
    .out_valid (conv_valid_s),
    .code      (conv_code_s)
  );

  assign wr_en   = conv_valid_s;
  assign wr_addr = addr_d_r;
  assign wr_data = blank_d_r ? BLANK_CODE : conv_code_s;
  assign done    = done_r;

endmodule

// File: tb/tb_hex_field_writer.sv
// Scoreboard bench for hex_field_writer: a field-level model queues the
// expected writes at accept time, a monitor pops and compares each write.
module tb_hex_field_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_value = 32'd0;
  logic [3:0]  req_ndigits = 4'd0;
  logic [10:0] req_addr = 11'd0;
  logic        req_lz_blank = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        done;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
    logic        fin;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  hex_field_writer #(.ADDR_W(11), .BLANK_CODE(8'd0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_value(req_value),
    .req_ndigits(req_ndigits), .req_addr(req_addr), .req_lz_blank(req_lz_blank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: digits, blanking and addresses from the field rules
  task automatic push_expected(input logic [31:0] v, input logic [3:0] nd,
                               input logic [10:0] a, input logic lz);
    int n;
    bit seen;
    n = (nd == 4'd0) ? 8 : int'(nd);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      int d;
      wr_t w;
      d = int'((v >> (4 * (n - 1 - i))) & 32'hF);
      if (lz && !seen && d == 0 && i != n - 1) w.data = 8'd0;
      else if (d < 10) w.data = 8'(16 + d);
      else w.data = 8'(33 + d - 10);
      if (d != 0) seen = 1;
      w.addr = 11'((int'(a) + i) % 2048);
      w.fin = (i == n - 1);
      exp_q.push_back(w);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr 0x%0h data %0d", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write", {13'd0, wr_addr, wr_data, done}, {13'd0, e.addr, e.data, e.fin});
        end
      end else if (done) begin
        check("done_without_write", 32'(done), 32'd0);
      end
    end
  end

  // Present a request, wait for accept, then scramble the inputs while busy
  task automatic issue(input logic [31:0] v, input logic [3:0] nd,
                       input logic [10:0] a, input logic lz, input bit keep_valid);
    int guard;
    req_valid = 1'b1; req_value = v; req_ndigits = nd; req_addr = a; req_lz_blank = lz;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    push_expected(v, nd, a, lz);
    #1;
    req_valid = keep_valid;
    req_value = $urandom;
    req_ndigits = 4'($urandom_range(0, 15));
    req_addr = 11'($urandom);
    req_lz_blank = 1'($urandom);
  endtask

  // Count busy cycles after accept: an N-digit field holds ready low N+1 cycles
  task automatic wait_idle(input logic [3:0] nd);
    int cnt;
    int n;
    n = (nd == 4'd0) ? 8 : int'(nd);
    cnt = 0;
    while (!req_ready && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(cnt), 32'(n + 1));
  endtask

  initial begin
    int base;
    int guard;
    logic [3:0] nd;
    #2;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_ready", 32'(req_ready), 32'd1);

    issue(32'h1234ABCD, 4'd0, 11'h040, 1'b0, 1'b0); wait_idle(4'd0);
    issue(32'h000000A5, 4'd4, 11'h100, 1'b1, 1'b0); wait_idle(4'd4);
    issue(32'h00000000, 4'd3, 11'h7FF, 1'b1, 1'b0); wait_idle(4'd3);

    // valid held high across two fields
    issue(32'hDEADBEEF, 4'd5, 11'h200, 1'b0, 1'b1); wait_idle(4'd5);
    issue(32'h00F00F00, 4'd6, 11'h7FC, 1'b1, 1'b0); wait_idle(4'd6);

    for (int k = 0; k < 40; k++) begin
      nd = 4'($urandom_range(0, 8));
      issue($urandom >> $urandom_range(0, 31), nd, 11'($urandom), 1'($urandom), 1'b0);
      wait_idle(nd);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // reset after the third write of an 8-digit field
    base = wr_cnt;
    issue(32'h89ABCDEF, 4'd8, 11'h3F0, 1'b0, 1'b0);
    guard = 0;
    while (wr_cnt < base + 3 && guard < 30) begin
      @(negedge clk); #1;
      guard++;
    end
    check("third_write_seen", 32'(wr_cnt - base), 32'd3);
    reset_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", 32'(req_ready), 32'd1);
    base = wr_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("no_writes_after_release", 32'(wr_cnt - base), 32'd0);

    issue(32'h0000C0DE, 4'd4, 11'h010, 1'b1, 1'b0); wait_idle(4'd4);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
